// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions: mux FSM state encoding
// and the default read data returned on a bus error.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_watchdog.sv
// Wait-cycle counter for the bus mux. expired pulses
// on the enabled cycle that brings the count to TIMEOUT.
//   clear   : forces count to 0 (has priority)
//   enable  : counts one wait cycle
//   expired : enable && count == TIMEOUT-1
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 16'd1;
  end

  assign expired = enable && !clear &&
                   (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_bus_mux.sv
// Single-master to NUM_SLAVES address-decoded bus mux
// with wait timeout and sticky error capture.
//   m_*   : master request / one-cycle completion
//   s_*   : one-hot slave requests, broadcast addr/data
//   bus_err/err_addr/err_clr : sticky first-error record
module mem_bus_mux
  import riscv_bus_pkg::*;
#(
  parameter int          NUM_SLAVES = 5,
  parameter int          SEL_MSB    = 15,
  parameter int          SEL_LSB    = 12,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  output logic                     bus_err,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;

  bus_state_e             state_q, state_d;
  logic [SEL_W-1:0]       idx_q, idx_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic                   bus_err_q, bus_err_d;
  logic [NUM_SLAVES-1:0]  sel_oh;
  logic [31:0]            sel_rdata;
  logic [SEL_W-1:0]       req_idx;
  logic                   req_ok;
  logic                   sel_ready;
  logic                   wd_clr, wd_en, wd_exp;
  logic                   err_ev;

  assign req_idx = m_addr[SEL_MSB:SEL_LSB];
  assign req_ok  = 32'(req_idx) < NUM_SLAVES;

  // Loop decode keeps the select index width
  // independent of NUM_SLAVES.
  always_comb begin
    sel_oh    = '0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (32'(idx_q) == i) begin
        sel_oh[i] = 1'b1;
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  assign sel_ready = |(s_ready & sel_oh);
  assign wd_clr    = (state_q != ACCESS);
  assign wd_en     = (state_q == ACCESS) && m_valid
                     && !sel_ready;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_valid) begin
          idx_d  = req_idx;
          addr_d = m_addr;
          if (req_ok) begin
            state_d = ACCESS;
          end else begin
            state_d = DONE;
            rdata_d = ERR_DATA;
            err_ev  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!m_valid) begin
          state_d = IDLE;
        end else if (sel_ready) begin
          state_d = DONE;
          rdata_d = sel_rdata;
        end else if (wd_exp) begin
          state_d = DONE;
          rdata_d = ERR_DATA;
          err_ev  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // addr_d already holds the faulting address in both
  // the decode-error and timeout paths. A clear arriving
  // with a new error re-arms capture for that error.
  always_comb begin
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    if (err_ev) begin
      bus_err_d = 1'b1;
      if (!bus_err_q || err_clr) err_addr_d = addr_d;
    end else if (err_clr) begin
      bus_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_ready  = (state_q == DONE);
  assign s_valid  = (state_q == ACCESS) ? sel_oh : '0;
  assign m_rdata  = rdata_q;
  assign s_addr   = m_addr;
  assign s_wdata  = m_wdata;
  assign s_wstrb  = m_wstrb;
  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_bus_mux.sv
// Directed bench for mem_bus_mux (5 slaves, TIMEOUT=8)
// with a scoreboard of expected completions.
module tb_mem_bus_mux;

  localparam int NS = 5;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          m_valid = 1'b0;
  logic          m_ready;
  logic [31:0]   m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic [3:0]    m_wstrb = '0;
  logic [31:0]   m_rdata;
  logic [NS-1:0] s_valid;
  logic [NS-1:0] s_ready = '0;
  logic [32*NS-1:0] s_rdata = '0;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_wstrb;
  logic          bus_err;
  logic [31:0]   err_addr;
  logic          err_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    logic [4:0]  sv;
  } exp_t;
  exp_t sb[$];

  mem_bus_mux #(
    .NUM_SLAVES (NS),
    .SEL_MSB    (15),
    .SEL_LSB    (12),
    .TIMEOUT    (8),
    .ERR_DATA   (ERR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .bus_err  (bus_err),
    .err_addr (err_addr),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation hung");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = ACCESS cycles before s_ready[idx]; n<0: never.
  // Non-selected slaves see s_ready=1 while waiting.
  task automatic txn(input string tag,
                     input logic [31:0] a,
                     input logic [3:0] w,
                     input int n,
                     input logic [31:0] d,
                     input logic [31:0] exp_rd,
                     input int exp_lat,
                     input logic [4:0] exp_sv,
                     input logic clr);
    int lat;
    int acc;
    logic done;
    logic [4:0] seen;
    exp_t e;
    m_valid = 1'b1;
    m_addr  = a;
    m_wstrb = w;
    m_wdata = ~a;
    err_clr = clr;
    sb.push_back('{exp_rd, exp_lat, exp_sv});
    lat  = 0;
    acc  = 0;
    done = 1'b0;
    seen = '0;
    chk({tag, "_saddr"}, s_addr, a);
    chk({tag, "_swstrb"}, 32'(s_wstrb), 32'(w));
    while (!done && lat < 40) begin
      step();
      lat++;
      err_clr = 1'b0;
      if (m_ready) begin
        done = 1'b1;
      end else if (s_valid != '0) begin
        seen |= s_valid;
        acc++;
        for (int i = 0; i < NS; i++)
          s_rdata[32*i +: 32] = s_valid[i] ? d
                                : (32'hBAD0_0000 | 32'(i));
        if (n >= 0 && acc == n + 1) s_ready = s_valid;
        else s_ready = ~s_valid;
      end
    end
    m_valid = 1'b0;
    s_ready = '0;
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_rdata"}, m_rdata, e.rdata);
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_svalid"}, 32'(seen), 32'(e.sv));
    step();
    chk({tag, "_mready_1cyc"}, 32'(m_ready), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mready", 32'(m_ready), 32'd0);
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    chk("rst_erraddr", err_addr, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    txn("rd_s1", 32'h1004, 4'b0000, 3, 32'h1234_5678,
        32'h1234_5678, 5, 5'b00010, 1'b0);
    chk("rd_s1_err", 32'(bus_err), 32'd0);

    txn("wr_s3", 32'h3000, 4'b0001, 0, 32'h5555_0000,
        32'h5555_0000, 2, 5'b01000, 1'b0);

    txn("dec_err", 32'h7000, 4'b0000, 0, 32'h0,
        ERR, 1, 5'b00000, 1'b0);
    chk("dec_err_flag", 32'(bus_err), 32'd1);
    chk("dec_err_addr", err_addr, 32'h7000);

    txn("to_s4", 32'h4010, 4'b0000, -1, 32'h0,
        ERR, 9, 5'b10000, 1'b0);
    chk("to_s4_flag", 32'(bus_err), 32'd1);
    chk("to_s4_addr_hold", err_addr, 32'h7000);

    txn("clr_err", 32'h9000, 4'b0000, 0, 32'h0,
        ERR, 1, 5'b00000, 1'b1);
    chk("clr_err_flag", 32'(bus_err), 32'd1);
    chk("clr_err_addr", err_addr, 32'h9000);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_only", 32'(bus_err), 32'd0);

    txn("to_s2", 32'h2000, 4'b0000, -1, 32'h0,
        ERR, 9, 5'b00100, 1'b0);
    chk("to_s2_flag", 32'(bus_err), 32'd1);
    chk("to_s2_addr", err_addr, 32'h2000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr2", 32'(bus_err), 32'd0);

    txn("edge_s2", 32'h2008, 4'b0000, 7, 32'hAAAA_5555,
        32'hAAAA_5555, 9, 5'b00100, 1'b0);
    chk("edge_s2_flag", 32'(bus_err), 32'd0);

    m_valid = 1'b1;
    m_addr  = 32'h1000;
    m_wstrb = 4'b0000;
    step();
    chk("abort_sv", 32'(s_valid), 32'h2);
    step();
    m_valid = 1'b0;
    step();
    chk("abort_idle_sv", 32'(s_valid), 32'd0);
    chk("abort_mready", 32'(m_ready), 32'd0);
    step();
    chk("abort_mready2", 32'(m_ready), 32'd0);
    chk("abort_rdata_hold", m_rdata, 32'hAAAA_5555);
    chk("abort_flag", 32'(bus_err), 32'd0);

    txn("dec_f", 32'hF000, 4'b0000, 0, 32'h0,
        ERR, 1, 5'b00000, 1'b0);
    chk("dec_f_addr", err_addr, 32'hF000);
    m_valid = 1'b1;
    m_addr  = 32'h1000;
    step();
    chk("pre_rst_sv", 32'(s_valid), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sv", 32'(s_valid), 32'd0);
    chk("mid_rst_mready", 32'(m_ready), 32'd0);
    chk("mid_rst_rdata", m_rdata, 32'd0);
    chk("mid_rst_flag", 32'(bus_err), 32'd0);
    chk("mid_rst_addr", err_addr, 32'd0);
    m_valid = 1'b0;
    step();
    rst_n = 1'b1;
    txn("post_rst", 32'h0000, 4'b0000, 1, 32'h0BAD_F00D,
        32'h0BAD_F00D, 3, 5'b00001, 1'b0);
    chk("post_rst_flag", 32'(bus_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
